// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: W-bit add/sub done serially through one shared 4-bit slice, LS nibble first
module nibble_add_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4*NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carryout,
  output logic         overflow,
  output logic         zero
);
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] ra, rb, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, c3, co, last;
  logic [3:0] an, bn, lo, s;
  logic [1:0] hi;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    an = ra[4*cnt +: 4];
    bn = rb[4*cnt +: 4];
    lo = {1'b0, an[2:0]} + {1'b0, bn[2:0]} + {3'b0, carry};
    c3 = lo[3];
    hi = {1'b0, an[3]} + {1'b0, bn[3]} + {1'b0, c3};
    s = {hi[0], lo[2:0]};
    co = hi[1];
    sum_nx = sum;
    sum_nx[4*cnt +: 4] = s;
    last = cnt == CW'(NIBBLES-1);
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b ^ {W{sub}};
        carry <= sub;
        cnt <= '0;
        sum <= '0;
      end else if (state == RUN) begin
        sum <= sum_nx;
        carry <= co;
        cnt <= last ? cnt : cnt + 1'b1;
        if (last) begin
          carryout <= co;
          overflow <= c3 ^ co;
          zero <= sum_nx == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: directed and random checks of the serial nibble adder
module tb_nibble_add_sequencer;
  logic clk = 1'b0;
  logic reset_n, in_valid, in_ready, sub, out_valid, out_ready, carryout, overflow, zero;
  logic [15:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  nibble_add_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (reset_n && out_valid && out_ready) handshakes <= handshakes + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, output int lat);
    a = ta;
    b = tb_;
    sub = ts;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  function automatic logic [18:0] ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rs);
    logic [15:0] bx;
    logic [16:0] r;
    bx = rb ^ {16{rs}};
    r = {1'b0, ra} + {1'b0, bx} + {16'b0, rs};
    return {r[15:0], r[16], (ra[15] == bx[15]) && (r[15] != ra[15]), r[15:0] == 16'h0};
  endfunction
  initial begin
    int lat, n;
    logic [18:0] held, exp;
    logic hs;
    reset_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {sum, carryout, overflow, zero}, 19'h0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rst_no_accept", in_ready, 1);
    issue(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("lat_7fff", lat, 4);
    chk("add_7fff", {sum, carryout, overflow, zero}, {16'h8000, 3'b010});
    handshake();
    chk("idle_after_hs", in_ready, 1);
    issue(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("lat_ffff", lat, 4);
    chk("add_ffff", {sum, carryout, overflow, zero}, {16'h0000, 3'b101});
    handshake();
    issue(16'h0005, 16'h0005, 1'b1, lat);
    chk("sub_5_5", {sum, carryout, overflow, zero}, {16'h0000, 3'b101});
    handshake();
    issue(16'h8000, 16'h0001, 1'b1, lat);
    chk("sub_8000_1", {sum, carryout, overflow, zero}, {16'h7FFF, 3'b110});
    handshake();
    a = 16'h0F0F;
    b = 16'h0101;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    chk("bp_busy", in_ready, 0);
    a = 16'hAAAA;
    b = 16'h5555;
    sub = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_done", out_valid, 1);
    held = {sum, carryout, overflow, zero};
    chk("bp_result", held, {16'h1010, 3'b000});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable", {sum, carryout, overflow, zero}, held);
      chk("bp_in_ready", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b1;
    handshake();
    chk("bp_next_accept_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accepted", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_next_result", {sum, carryout, overflow, zero}, ref_model(16'hAAAA, 16'h5555, 1'b1));
    handshake();
    tick();
    chk("bp_not_queued", out_valid, 0);
    a = 16'hFFFF;
    b = 16'hFFFF;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst", {in_ready, out_valid, sum}, {2'b10, 16'h0000});
    tick();
    chk("mid_rst_stay", {in_ready, out_valid}, 2'b10);
    issue(16'h1234, 16'h1111, 1'b0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_add", {sum, carryout, overflow}, {16'h2345, 2'b00});
    handshake();
    handshakes = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      exp = ref_model(ra, rb, rs);
      issue(ra, rb, rs, lat);
      if (lat != 4) chk("rnd_lat", lat, 4);
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
        out_ready = 1'($urandom);
        hs = out_ready;
        if ({sum, carryout, overflow, zero} !== exp || !out_valid) chk("rnd_result", {out_valid, sum, carryout, overflow, zero}, {1'b1, exp});
        tick();
        n++;
      end
      out_ready = 1'b0;
      if (!hs) chk("rnd_hs_timeout", n, 0);
    end
    tick();
    chk("rnd_count", handshakes, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_add_sequencer.md
NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit slices (W = 4*NIBBLES).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  W  first operand, 2's complement.
REQ-007 b  input  W  second operand, 2's complement.
REQ-008 sub  input  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  2's complement result.
REQ-012 carryout  output  1  carry out of the MSB slice (for sub, 1 = no borrow).
REQ-013 overflow  output  1  signed overflow of the W-bit operation.
REQ-014 zero  output  1  sum == 0.

Function
REQ-015 The block SHALL compute the W-bit result with one shared 4-bit adder slice (carry-in, 4-bit sum, carry into bit 3, carry out), one nibble per cycle, LS nibble first.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid && in_ready, latch a, b XOR {W{sub}}, carry = sub, nibble counter = 0, clear sum, go to RUN; otherwise stay in IDLE.
REQ-018 RUN: each cycle, add nibble[cnt] of latched a and b with the carry register, write sum nibble[cnt], store carry-out, increment cnt.
REQ-019 RUN: on the cycle cnt == NIBBLES-1, latch carryout = slice carry-out and overflow = slice carry into bit 3 XOR slice carry-out, then go to DONE.
REQ-020 zero SHALL be registered as (full W-bit sum == 0) on entry to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES cycles after the acceptance edge.
REQ-022 DONE: sum, carryout, overflow, zero SHALL hold stable until the out_valid && out_ready edge, then the FSM returns to IDLE.
REQ-023 Minimum request-to-request period SHALL be NIBBLES+2 cycles; in_valid outside IDLE SHALL be ignored and not queued.
REQ-024 Operand inputs SHALL be sampled only at acceptance; changes during RUN/DONE SHALL not affect the result.
REQ-025 Arithmetic SHALL wrap modulo 2^W; carryout and overflow SHALL match a single W-bit ripple adder with carry-in = sub.
REQ-026 Counter SHALL be ceil(log2(NIBBLES)) bits (minimum 1) and SHALL never index past nibble NIBBLES-1.

Reset
REQ-027 While reset_n = 0 at a rising edge, the block SHALL enter IDLE with sum = 0, carryout = 0, overflow = 0, zero = 0, out_valid = 0, carry and counter cleared.
REQ-028 Reset in RUN or DONE SHALL discard the in-flight operation; in_ready = 1 on the first cycle after reset_n returns high.
REQ-029 in_valid asserted in the same cycle reset_n is low SHALL not be accepted.

Verification (NIBBLES = 4)
REQ-030 add 0x7FFF + 0x0001 -> sum 0x8000, carryout 0, overflow 1, zero 0; out_valid exactly 4 cycles after acceptance.
REQ-031 add 0xFFFF + 0x0001 -> sum 0x0000, carryout 1, overflow 0, zero 1.
REQ-032 sub 0x0005 - 0x0005 -> sum 0x0000, carryout 1, overflow 0, zero 1; sub 0x8000 - 0x0001 -> sum 0x7FFF, carryout 1, overflow 1.
REQ-033 Backpressure: out_ready low for 3 cycles in DONE -> outputs stable, in_ready 0; in_valid pulses during RUN ignored; next request accepted only after the handshake edge.
REQ-034 reset_n low for one edge during RUN (cnt = 2) -> next cycle IDLE, out_valid 0, sum 0x0000, in_ready 1; a following add 0x1234 + 0x1111 -> sum 0x2345, carryout 0, overflow 0.
REQ-035 Randomized: 1000 requests with random a, b, sub and random out_ready -> every result matches the W-bit reference model; no result lost or duplicated.
